// File: rtl/c7bbiu_rd_arb_rr.sv
// ---------------------------------------------------------------------------
// c7bbiu_rd_arb_rr
//   AXI read-address arbiter for the BIU. Picks one of NREQ requesters per
//   cycle (round-robin or fixed priority), loads the winner into a registered
//   AR slot with a full valid/ready handshake, tags the AR with ID = requester
//   index and tracks outstanding read bursts against MAX_OUTST.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_val/req_ack     per-requester request / one-hot combinational ack
//   req_addr/len/incr   packed per-requester AR fields (slice i = requester i)
//   axi_ar_*            registered AXI AR channel
//   axi_r_valid/ready/last  R-channel observation for burst completion
//   outst_cnt           bursts accepted on AR whose last R beat is not seen
//   arb_busy            outstanding bursts or AR slot occupied
// ---------------------------------------------------------------------------
module c7bbiu_rd_arb_rr #(
  parameter int NREQ      = 3,
  parameter int AW        = 32,
  parameter int IDW       = 4,
  parameter int MAX_OUTST = 4,
  parameter int RR_EN     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_val,
  output logic [NREQ-1:0]    req_ack,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_len,
  input  logic [NREQ-1:0]    req_incr,
  output logic               axi_ar_valid,
  input  logic               axi_ar_ready,
  output logic [IDW-1:0]     axi_ar_id,
  output logic [AW-1:0]      axi_ar_addr,
  output logic [7:0]         axi_ar_len,
  output logic [2:0]         axi_ar_size,
  output logic [1:0]         axi_ar_burst,
  output logic               axi_ar_lock,
  output logic [3:0]         axi_ar_cache,
  output logic [2:0]         axi_ar_prot,
  input  logic               axi_r_valid,
  input  logic               axi_r_ready,
  input  logic               axi_r_last,
  output logic [3:0]         outst_cnt,
  output logic               arb_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Lowest set index of a request vector (fixed priority, index 0 first).
  function automatic logic [PTR_W-1:0] lowest_set(input logic [NREQ-1:0] v);
    logic [PTR_W-1:0] w;
    w = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) w = PTR_W'(i);
    end
    return w;
  endfunction

  // Round-robin pick: rotate the request vector so ptr lands on bit 0, take
  // the lowest set bit as an offset and map it back modulo NREQ.
  function automatic logic [PTR_W-1:0] pick_rr(input logic [NREQ-1:0] v,
                                               input logic [PTR_W-1:0] ptr);
    logic [2*NREQ-1:0] vv;
    logic [NREQ-1:0]   rot;
    logic [PTR_W-1:0]  off;
    logic [PTR_W:0]    sum;
    vv  = {v, v} >> ptr;
    rot = vv[NREQ-1:0];
    off = lowest_set(rot);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
    return sum[PTR_W-1:0];
  endfunction

  // Next round-robin pointer: one past the winner, wrapping at NREQ.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    logic [PTR_W-1:0] n;
    if (w == PTR_W'(NREQ - 1)) n = '0;
    else                       n = w + PTR_W'(1);
    return n;
  endfunction

  logic [PTR_W-1:0] rr_ptr;
  logic             slot_free_p0;
  logic             room_p0;
  logic             grant_p0;
  logic [PTR_W-1:0] win_p0;
  logic             inc_p0;
  logic             dec_p0;

  // ---- stage p0: arbitration (combinational, same cycle as req_val) ----
  always_comb begin
    // The AR slot can take a new request when empty or draining this cycle.
    slot_free_p0 = ~axi_ar_valid | axi_ar_ready;
    // An occupied AR slot is not yet counted in outst_cnt but will be, so it
    // is charged against the limit here; this keeps back-to-back issue from
    // overshooting MAX_OUTST.
    room_p0 = ({1'b0, outst_cnt} + 5'(axi_ar_valid)) < 5'(MAX_OUTST);
    grant_p0 = ~reset & slot_free_p0 & room_p0 & (|req_val);
    if (RR_EN != 0) win_p0 = pick_rr(req_val, rr_ptr);
    else            win_p0 = lowest_set(req_val);
    req_ack = '0;
    if (grant_p0) req_ack = NREQ'(1) << win_p0;
  end

  assign inc_p0 = axi_ar_valid & axi_ar_ready;
  assign dec_p0 = axi_r_valid & axi_r_ready & axi_r_last;

  // ---- stage p1: registered AR channel, pointer and burst counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      axi_ar_valid <= 1'b0;
      axi_ar_id    <= '0;
      axi_ar_addr  <= '0;
      axi_ar_len   <= '0;
      axi_ar_size  <= '0;
      axi_ar_burst <= '0;
    end else begin
      if (grant_p0) begin
        axi_ar_valid <= 1'b1;
        axi_ar_id    <= IDW'(win_p0);
        axi_ar_addr  <= req_addr[win_p0*AW +: AW];
        axi_ar_len   <= req_len[win_p0*8 +: 8];
        axi_ar_size  <= 3'b011;
        axi_ar_burst <= {1'b0, req_incr[win_p0]};
        if (RR_EN != 0) rr_ptr <= next_ptr(win_p0);
      end else if (inc_p0) begin
        axi_ar_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst_cnt <= '0;
    end else if (inc_p0 && !dec_p0) begin
      outst_cnt <= outst_cnt + 4'd1;
    end else if (dec_p0 && !inc_p0 && outst_cnt != 4'd0) begin
      // A stray last beat with nothing outstanding saturates at zero.
      outst_cnt <= outst_cnt - 4'd1;
    end
  end

  assign axi_ar_lock  = 1'b0;
  assign axi_ar_cache = 4'b0000;
  assign axi_ar_prot  = 3'b000;
  assign arb_busy     = (outst_cnt != 4'd0) | axi_ar_valid;

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(dec_p0 && !inc_p0 && outst_cnt == 4'd0));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    outst_cnt <= 4'(MAX_OUTST));

endmodule

// File: tb/tb_c7bbiu_rd_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_c7bbiu_rd_arb_rr
//   Directed bench for c7bbiu_rd_arb_rr. Three instances share request and
//   AR-ready stimulus: round-robin (MAX_OUTST=8), fixed priority
//   (MAX_OUTST=15) and round-robin with MAX_OUTST=2.
// ---------------------------------------------------------------------------
module tb_c7bbiu_rd_arb_rr;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int IDW  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_val;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*8-1:0]  req_len;
  logic [NREQ-1:0]    req_incr;
  logic               ar_ready;
  logic               rv_m, rv_l;
  logic               r_ready = 1'b1;
  logic               r_last  = 1'b1;

  logic [NREQ-1:0] ack_m, ack_f, ack_l;
  logic            val_m, val_f, val_l;
  logic [IDW-1:0]  id_m, id_f, id_l;
  logic [AW-1:0]   addr_m, addr_f, addr_l;
  logic [7:0]      len_m, len_f, len_l;
  logic [2:0]      size_m, size_f, size_l;
  logic [1:0]      burst_m, burst_f, burst_l;
  logic            lock_m, lock_f, lock_l;
  logic [3:0]      cache_m, cache_f, cache_l;
  logic [2:0]      prot_m, prot_f, prot_l;
  logic [3:0]      cnt_m, cnt_f, cnt_l;
  logic            busy_m, busy_f, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  c7bbiu_rd_arb_rr #(.NREQ(NREQ), .AW(AW), .IDW(IDW), .MAX_OUTST(8), .RR_EN(1)) u_main (
    .clk(clk), .reset(reset), .req_val(req_val), .req_ack(ack_m),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .axi_ar_valid(val_m), .axi_ar_ready(ar_ready), .axi_ar_id(id_m),
    .axi_ar_addr(addr_m), .axi_ar_len(len_m), .axi_ar_size(size_m),
    .axi_ar_burst(burst_m), .axi_ar_lock(lock_m), .axi_ar_cache(cache_m),
    .axi_ar_prot(prot_m), .axi_r_valid(rv_m), .axi_r_ready(r_ready),
    .axi_r_last(r_last), .outst_cnt(cnt_m), .arb_busy(busy_m));

  c7bbiu_rd_arb_rr #(.NREQ(NREQ), .AW(AW), .IDW(IDW), .MAX_OUTST(15), .RR_EN(0)) u_fixed (
    .clk(clk), .reset(reset), .req_val(req_val), .req_ack(ack_f),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .axi_ar_valid(val_f), .axi_ar_ready(ar_ready), .axi_ar_id(id_f),
    .axi_ar_addr(addr_f), .axi_ar_len(len_f), .axi_ar_size(size_f),
    .axi_ar_burst(burst_f), .axi_ar_lock(lock_f), .axi_ar_cache(cache_f),
    .axi_ar_prot(prot_f), .axi_r_valid(1'b0), .axi_r_ready(r_ready),
    .axi_r_last(r_last), .outst_cnt(cnt_f), .arb_busy(busy_f));

  c7bbiu_rd_arb_rr #(.NREQ(NREQ), .AW(AW), .IDW(IDW), .MAX_OUTST(2), .RR_EN(1)) u_lim (
    .clk(clk), .reset(reset), .req_val(req_val), .req_ack(ack_l),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .axi_ar_valid(val_l), .axi_ar_ready(ar_ready), .axi_ar_id(id_l),
    .axi_ar_addr(addr_l), .axi_ar_len(len_l), .axi_ar_size(size_l),
    .axi_ar_burst(burst_l), .axi_ar_lock(lock_l), .axi_ar_cache(cache_l),
    .axi_ar_prot(prot_l), .axi_r_valid(rv_l), .axi_r_ready(r_ready),
    .axi_r_last(r_last), .outst_cnt(cnt_l), .arb_busy(busy_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req_val  = '0;
    ar_ready = 1'b0;
    rv_m     = 1'b0;
    rv_l     = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req_val  = '0;
    req_addr = '0;
    req_len  = '0;
    req_incr = '0;
    ar_ready = 1'b0;
    rv_m     = 1'b0;
    rv_l     = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ar_valid", 32'(val_m), 32'd0);
    chk("rst_ack",      32'(ack_m), 32'd0);
    chk("rst_cnt",      32'(cnt_m), 32'd0);
    chk("rst_addr",     addr_m,     32'd0);
    chk("rst_size",     32'(size_m), 32'd0);
    chk("rst_busy",     32'(busy_m), 32'd0);
    reset = 1'b0;

    // 1) Single request from requester 2
    req_addr[2*AW +: AW] = 32'h0000_1000;
    req_len[2*8 +: 8]    = 8'd3;
    req_incr[2]          = 1'b1;
    req_val              = 3'b100;
    #1 chk("t1_ack", 32'(ack_m), 32'b100);
    tick();
    req_val = '0;
    chk("t1_valid", 32'(val_m),   32'd1);
    chk("t1_id",    32'(id_m),    32'd2);
    chk("t1_addr",  addr_m,       32'h1000);
    chk("t1_len",   32'(len_m),   32'd3);
    chk("t1_burst", 32'(burst_m), 32'b01);
    chk("t1_size",  32'(size_m),  32'b011);
    chk("t1_busy",  32'(busy_m),  32'd1);
    ar_ready = 1'b1;
    tick();
    chk("t1_drain_valid", 32'(val_m), 32'd0);
    chk("t1_cnt_inc",     32'(cnt_m), 32'd1);
    ar_ready = 1'b0;
    rv_m     = 1'b1;
    tick();
    rv_m = 1'b0;
    chk("t1_cnt_dec", 32'(cnt_m), 32'd0);

    // 2) Round-robin with all three requesting and AR always ready
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = 32'h100 * (i + 1);
      req_len[i*8 +: 8]    = 8'(i);
      req_incr[i]          = 1'b1;
    end
    req_val  = 3'b111;
    ar_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t2_ack%0d", k), 32'(ack_m), 32'(3'b001 << (k % 3)));
      tick();
      chk($sformatf("t2_valid%0d", k), 32'(val_m), 32'd1);
      chk($sformatf("t2_id%0d", k),    32'(id_m),  32'(k % 3));
    end
    req_val = '0;

    // 3) Fixed priority: requester 1 always beats requester 2
    do_reset();
    req_val  = 3'b110;
    ar_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_ack%0d", k), 32'(ack_f), 32'b010);
      tick();
      chk($sformatf("t3_id%0d", k), 32'(id_f), 32'd1);
    end
    req_val = '0;

    // 4) Outstanding limit of 2 with no R beats
    do_reset();
    req_val  = 3'b001;
    ar_ready = 1'b1;
    #1 chk("t4_ack0", 32'(ack_l), 32'b001);
    tick();
    #1 chk("t4_ack1", 32'(ack_l), 32'b001);
    tick();
    #1 chk("t4_ack2_blocked", 32'(ack_l), 32'd0);
    tick();
    chk("t4_cnt2",  32'(cnt_l), 32'd2);
    chk("t4_valid", 32'(val_l), 32'd0);
    rv_l = 1'b1;
    #1 chk("t4_ack3_blocked", 32'(ack_l), 32'd0);
    tick();
    rv_l = 1'b0;
    chk("t4_cnt1", 32'(cnt_l), 32'd1);
    #1 chk("t4_ack_after_r", 32'(ack_l), 32'b001);
    req_val = '0;

    // 5) Backpressure, then back-to-back issue
    do_reset();
    req_addr[0*AW +: AW] = 32'h0000_A000;
    req_len[0*8 +: 8]    = 8'd7;
    req_incr[0]          = 1'b0;
    req_addr[1*AW +: AW] = 32'h0000_B000;
    req_len[1*8 +: 8]    = 8'd2;
    req_incr[1]          = 1'b1;
    req_val = 3'b001;
    #1 chk("t5_ack0", 32'(ack_m), 32'b001);
    tick();
    req_val = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t5_hold_ack%0d", k),   32'(ack_m),   32'd0);
      chk($sformatf("t5_hold_addr%0d", k),  addr_m,       32'hA000);
      chk($sformatf("t5_hold_len%0d", k),   32'(len_m),   32'd7);
      chk($sformatf("t5_hold_burst%0d", k), 32'(burst_m), 32'b00);
      chk($sformatf("t5_hold_valid%0d", k), 32'(val_m),   32'd1);
      tick();
    end
    ar_ready = 1'b1;
    #1 chk("t5_b2b_ack", 32'(ack_m), 32'b010);
    tick();
    req_val = '0;
    chk("t5_b2b_valid", 32'(val_m),   32'd1);
    chk("t5_b2b_id",    32'(id_m),    32'd1);
    chk("t5_b2b_addr",  addr_m,       32'hB000);
    chk("t5_b2b_burst", 32'(burst_m), 32'b01);
    chk("t5_cnt",       32'(cnt_m),   32'd1);

    // 6a) inc and dec in the same cycle at cnt=1
    rv_m = 1'b1;
    tick();
    rv_m     = 1'b0;
    ar_ready = 1'b0;
    chk("t6_inc_dec_cnt", 32'(cnt_m), 32'd1);

    // 6b) asynchronous reset with three bursts outstanding
    do_reset();
    req_val  = 3'b001;
    ar_ready = 1'b1;
    repeat (4) tick();
    req_val  = '0;
    ar_ready = 1'b0;
    chk("t6_cnt3",   32'(cnt_m), 32'd3);
    chk("t6_valid1", 32'(val_m), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_cnt",   32'(cnt_m),  32'd0);
    chk("t6_async_valid", 32'(val_m),  32'd0);
    chk("t6_async_addr",  addr_m,      32'd0);
    chk("t6_async_busy",  32'(busy_m), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
